// File: rtl/gelato_fetch_scheduler_pkg.sv
// +----------------------------------------------------------------------+
// | gelato_types : shared warp/fetch types for the gelato front end       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package gelato_types;

    localparam int NUM_WARPS   = 4;
    localparam int WARP_NUM_W  = $clog2(NUM_WARPS);
    localparam int SPLIT_NUM_W = 4;

    typedef logic [WARP_NUM_W-1:0]  warp_num_t;
    typedef logic [SPLIT_NUM_W-1:0] split_num_t;

    typedef struct packed {
        logic [31:0] pc;
        warp_num_t   warp_num;
        split_num_t  split_table_num;
    } pc_info_t;

    typedef enum logic [1:0] {
        WARP_IDLE     = 2'd0,
        WARP_READY    = 2'd1,
        WARP_FETCHING = 2'd2
    } warp_state_t;

endpackage

`default_nettype wire

// File: rtl/gelato_fetch_scheduler_if.sv
// +----------------------------------------------------------------------+
// | gelato_fetch_scheduler_if : launch, next-PC feedback and fetch bus    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface gelato_fetch_scheduler_if;
    import gelato_types::*;

    logic        launch_valid;
    logic        launch_ready;
    warp_num_t   launch_warp_num;
    logic [31:0] launch_pc;
    split_num_t  launch_split;

    logic        upd_valid;
    warp_num_t   upd_warp_num;
    logic [31:0] upd_pc;
    logic        upd_exit;

    logic        dout_valid;
    logic        dout_ready;
    pc_info_t    dout;

    modport master (
        output launch_valid, launch_warp_num, launch_pc, launch_split,
        output upd_valid, upd_warp_num, upd_pc, upd_exit,
        output dout_ready,
        input  launch_ready, dout_valid, dout
    );

    modport slave (
        input  launch_valid, launch_warp_num, launch_pc, launch_split,
        input  upd_valid, upd_warp_num, upd_pc, upd_exit,
        input  dout_ready,
        output launch_ready, dout_valid, dout
    );

endinterface

`default_nettype wire

// File: rtl/gelato_fetch_scheduler_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | gelato_rr_arbiter : combinational round-robin grant starting at ptr   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module gelato_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int W = $clog2(N);

    logic [W-1:0] cand;

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr + W'(i);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gelato_fetch_scheduler.sv
// +----------------------------------------------------------------------+
// | gelato_fetch_scheduler : per-warp PC table with round-robin issue     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module gelato_fetch_scheduler #(
    parameter int NUM_WARPS    = gelato_types::NUM_WARPS,
    parameter int RR_RESET_PTR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    gelato_fetch_scheduler_if.slave bus,
    output logic [NUM_WARPS-1:0] active_mask,
    output logic                 all_idle,
    output logic                 err
);
    import gelato_types::*;

    localparam int WW = $clog2(NUM_WARPS);

    warp_state_t  state_q [NUM_WARPS];
    warp_state_t  state_d [NUM_WARPS];
    logic [31:0]  pc_q    [NUM_WARPS];
    split_num_t   split_q [NUM_WARPS];
    logic [WW-1:0] rr_ptr;

    logic [NUM_WARPS-1:0] req;
    logic                 gnt_valid;
    logic [WW-1:0]        gnt_idx;

    logic     launch_fire;
    logic     upd_ok;
    logic     slot_free;
    logic     issue;
    logic     err_set;
    logic     dout_valid_q;
    pc_info_t dout_q;

    assign bus.launch_ready = (state_q[bus.launch_warp_num] == WARP_IDLE);
    assign launch_fire      = bus.launch_valid && bus.launch_ready;
    assign upd_ok           = bus.upd_valid && (state_q[bus.upd_warp_num] == WARP_FETCHING);
    assign err_set          = (bus.launch_valid && !bus.launch_ready) || (bus.upd_valid && !upd_ok);
    assign slot_free        = !dout_valid_q || bus.dout_ready;
    assign issue            = slot_free && gnt_valid;

    gelato_rr_arbiter #(.N(NUM_WARPS)) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // A legal launch needs IDLE, a legal update FETCHING and an issue READY,
    // so at most one of these can touch any given warp per cycle.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            state_d[w]     = state_q[w];
            req[w]         = (state_q[w] == WARP_READY);
            active_mask[w] = (state_q[w] != WARP_IDLE);
            if (launch_fire && bus.launch_warp_num == WW'(w))
                state_d[w] = WARP_READY;
            if (upd_ok && bus.upd_warp_num == WW'(w))
                state_d[w] = bus.upd_exit ? WARP_IDLE : WARP_READY;
            if (issue && gnt_idx == WW'(w))
                state_d[w] = WARP_FETCHING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= WARP_IDLE;
                pc_q[w]    <= '0;
                split_q[w] <= '0;
            end
            rr_ptr       <= WW'(RR_RESET_PTR);
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            err          <= 1'b0;
        end else if (rdy) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= state_d[w];
                if (launch_fire && bus.launch_warp_num == WW'(w)) begin
                    pc_q[w]    <= bus.launch_pc;
                    split_q[w] <= bus.launch_split;
                end
                if (upd_ok && !bus.upd_exit && bus.upd_warp_num == WW'(w))
                    pc_q[w] <= bus.upd_pc;
            end
            if (issue) begin
                dout_q.pc              <= pc_q[gnt_idx];
                dout_q.warp_num        <= gnt_idx;
                dout_q.split_table_num <= split_q[gnt_idx];
                dout_valid_q           <= 1'b1;
                rr_ptr                 <= gnt_idx + WW'(1);
            end else if (slot_free) begin
                dout_valid_q <= 1'b0;
            end
            if (err_set)
                err <= 1'b1;
        end
    end

    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;
    assign all_idle       = (active_mask == '0) && !dout_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_gelato_fetch_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_gelato_fetch_scheduler : directed bench with a behavioural model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_gelato_fetch_scheduler;
    import gelato_types::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [3:0] active_mask;
    logic       all_idle;
    logic       err;

    gelato_fetch_scheduler_if bus();

    gelato_fetch_scheduler #(.NUM_WARPS(4), .RR_RESET_PTR(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .bus         (bus),
        .active_mask (active_mask),
        .all_idle    (all_idle),
        .err         (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Model: 0 = idle, 1 = ready, 2 = fetching
    int          ms   [4];
    logic [31:0] mpc  [4];
    logic [3:0]  msp  [4];
    int          mptr;
    bit          mdv;
    pc_info_t    md;
    bit          merr;

    int          log_w  [$];
    logic [31:0] log_pc [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int  g, lw, uw;
        bit  lfire, lbad, uok, ubad, free;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                ms[k] = 0; mpc[k] = 32'h0; msp[k] = 4'h0;
            end
            mptr = 0; mdv = 1'b0; md = '0; merr = 1'b0;
        end else if (rdy) begin
            lw    = int'(bus.launch_warp_num);
            uw    = int'(bus.upd_warp_num);
            lfire = bus.launch_valid && ms[lw] == 0;
            lbad  = bus.launch_valid && ms[lw] != 0;
            uok   = bus.upd_valid && ms[uw] == 2;
            ubad  = bus.upd_valid && ms[uw] != 2;
            free  = !mdv || bus.dout_ready;
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && ms[(mptr + k) % 4] == 1) g = (mptr + k) % 4;
            if (lfire) begin
                ms[lw] = 1; mpc[lw] = bus.launch_pc; msp[lw] = bus.launch_split;
            end
            if (uok) begin
                if (bus.upd_exit) ms[uw] = 0;
                else begin ms[uw] = 1; mpc[uw] = bus.upd_pc; end
            end
            if (lbad || ubad) merr = 1'b1;
            if (free) begin
                if (g >= 0) begin
                    md.pc = mpc[g]; md.warp_num = 2'(g); md.split_table_num = msp[g];
                    mdv = 1'b1; ms[g] = 2; mptr = (g + 1) % 4;
                end else begin
                    mdv = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] em;
        if (cmp_en) begin
            for (int k = 0; k < 4; k++) em[k] = (ms[k] != 0);
            chk("dout_valid", 64'(bus.dout_valid), 64'(mdv));
            chk("dout", 64'(bus.dout), 64'(md));
            chk("active_mask", 64'(active_mask), 64'(em));
            chk("all_idle", 64'(all_idle), 64'(em == 4'h0 && !mdv));
            chk("err", 64'(err), 64'(merr));
            chk("launch_ready", 64'(bus.launch_ready), 64'(ms[int'(bus.launch_warp_num)] == 0));
            if (bus.dout_valid && bus.dout_ready && rdy && !rst) begin
                log_w.push_back(int'(bus.dout.warp_num));
                log_pc.push_back(bus.dout.pc);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic peek();
        @(negedge clk); #2;
    endtask

    task automatic clr();
        bus.launch_valid = 1'b0;
        bus.upd_valid    = 1'b0;
        bus.upd_exit     = 1'b0;
    endtask

    task automatic launch(input int w, input logic [31:0] pc, input logic [3:0] sp);
        bus.launch_valid    = 1'b1;
        bus.launch_warp_num = 2'(w);
        bus.launch_pc       = pc;
        bus.launch_split    = sp;
    endtask

    task automatic upd(input int w, input logic [31:0] pc, input logic ex);
        bus.upd_valid    = 1'b1;
        bus.upd_warp_num = 2'(w);
        bus.upd_pc       = pc;
        bus.upd_exit     = ex;
    endtask

    initial begin
        pc_info_t held;
        rst = 1'b1; rdy = 1'b1;
        clr();
        bus.launch_warp_num = 2'd0; bus.launch_pc = 32'h0; bus.launch_split = 4'h0;
        bus.upd_warp_num = 2'd0; bus.upd_pc = 32'h0; bus.dout_ready = 1'b0;
        step(2);
        cmp_en = 1'b1;
        peek();
        chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
        chk("rst_mask", 64'(active_mask), 64'h0);
        chk("rst_all_idle", 64'(all_idle), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;

        // Single launch: dout appears one cycle after the launch edge
        launch(0, 32'h1000, 4'd2);
        step(); clr();
        peek();
        chk("t1_mask", 64'(active_mask), 64'h1);
        chk("t1_valid_early", 64'(bus.dout_valid), 64'd0);
        step();
        peek();
        chk("t1_valid", 64'(bus.dout_valid), 64'd1);
        chk("t1_dout", 64'(bus.dout), {26'd0, 32'h1000, 2'd0, 4'd2});
        bus.dout_ready = 1'b1;
        step();
        upd(0, 32'h0, 1'b1);
        step(); clr();
        peek();
        chk("t1_retired", 64'(all_idle), 64'd1);

        // Four launches back to back, issue in order 0..3
        log_w.delete(); log_pc.delete();
        for (int w = 0; w < 4; w++) begin
            launch(w, 32'((w + 1) << 8), 4'(w + 4));
            step();
        end
        clr();
        step(4);
        peek();
        chk("t2_count", 64'(log_w.size()), 64'd4);
        for (int k = 0; k < 4 && k < log_w.size(); k++) begin
            chk("t2_order", 64'(log_w[k]), 64'(k));
            chk("t2_pc", 64'(log_pc[k]), 64'((k + 1) << 8));
        end
        chk("t2_mask", 64'(active_mask), 64'hF);
        chk("t2_idle_issue", 64'(bus.dout_valid), 64'd0);

        // Back-pressure: warp 1 holds on dout, warp 2 follows after release
        bus.dout_ready = 1'b0;
        upd(1, 32'h104, 1'b0);
        step();
        upd(2, 32'h208, 1'b0);
        step(); clr();
        peek();
        held = bus.dout;
        chk("t3_held_first", 64'(held), {26'd0, 32'h104, 2'd1, 4'd5});
        for (int k = 0; k < 5; k++) begin
            step();
            peek();
            chk("t3_stall_valid", 64'(bus.dout_valid), 64'd1);
            chk("t3_stall_dout", 64'(bus.dout), {26'd0, 32'h104, 2'd1, 4'd5});
        end
        bus.dout_ready = 1'b1;
        step();
        peek();
        chk("t3_next", 64'(bus.dout), {26'd0, 32'h208, 2'd2, 4'd6});
        step();

        // Resume then retire warp 1
        log_w.delete(); log_pc.delete();
        upd(1, 32'h204, 1'b0);
        step(); clr();
        step(3);
        chk("t4_count", 64'(log_w.size()), 64'd1);
        if (log_w.size() > 0) begin
            chk("t4_warp", 64'(log_w[0]), 64'd1);
            chk("t4_pc", 64'(log_pc[0]), 64'h204);
        end
        upd(1, 32'h0, 1'b1);
        step(); clr();
        bus.launch_warp_num = 2'd1;
        peek();
        chk("t4_mask", 64'(active_mask), 64'hD);
        chk("t4_launch_ready", 64'(bus.launch_ready), 64'd1);

        // Illegal update and illegal launch in one cycle
        upd(1, 32'h0, 1'b0);
        launch(0, 32'hDEAD, 4'd1);
        step(); clr();
        peek();
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_mask", 64'(active_mask), 64'hD);
        step(3);
        peek();
        chk("t5_err_sticky", 64'(err), 64'd1);

        // rdy low freezes everything, then the held launch lands
        rdy = 1'b0;
        launch(1, 32'h500, 4'd7);
        step(2);
        peek();
        chk("t5_rdy_hold", 64'(active_mask), 64'hD);
        rdy = 1'b1;
        step(); clr();
        peek();
        chk("t5_rdy_launch", 64'(active_mask), 64'hF);
        step(2);
        upd(3, 32'h0, 1'b1);
        step(); clr();
        launch(3, 32'h700, 4'd3);
        upd(2, 32'h20C, 1'b0);
        step(); clr();
        peek();
        chk("t5_both", 64'(active_mask), 64'hF);

        // Reset in the middle of a stalled issue
        bus.dout_ready = 1'b0;
        step(2);
        peek();
        chk("t6_pre_valid", 64'(bus.dout_valid), 64'd1);
        chk("t6_pre_err", 64'(err), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        peek();
        chk("t6_valid", 64'(bus.dout_valid), 64'd0);
        chk("t6_mask", 64'(active_mask), 64'h0);
        chk("t6_all_idle", 64'(all_idle), 64'd1);
        chk("t6_err", 64'(err), 64'd0);
        step(2);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gelato_fetch_scheduler.md
Name: gelato_fetch_scheduler

Overview:
- Per-warp PC scheduler that feeds the instruction fetch unit through its din_valid/din_ready/pc_info_t port.
- Holds PC, split-table number and fetch status for every warp.
- Picks one eligible warp per issue slot using round-robin and allows only one outstanding fetch per warp.
- Warps are launched by the dispatcher and resumed, redirected or retired by the downstream next-PC feedback path.

Parameters:
- NUM_WARPS, 4, number of warp slots; must be a power of two and match the gelato_types warp_num width.
- RR_RESET_PTR, 0, warp index that receives priority first after reset.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- rdy  input  1  global enable; when low, all state and outputs hold
- launch_valid  input  1  dispatcher launches a warp
- launch_ready  output  1  high when the slot at launch_warp_num is IDLE (combinational)
- launch_warp_num  input  $clog2(NUM_WARPS)  slot to launch
- launch_pc  input  32  start PC
- launch_split  input  split_table_num width  initial split-table entry
- upd_valid  input  1  next-PC feedback for a warp in FETCHING
- upd_warp_num  input  $clog2(NUM_WARPS)  warp being resumed
- upd_pc  input  32  next PC (pc+4 or branch target)
- upd_exit  input  1  warp finished; retire the slot instead of resuming it
- dout_valid  output  1  pc_info_t valid toward instruction fetch (registered)
- dout_ready  input  1  instruction fetch accepts
- dout  output  pc_info_t  {pc, warp_num, split_table_num} (registered)
- active_mask  output  NUM_WARPS  bit w set when warp w is not IDLE
- all_idle  output  1  high when active_mask == 0 and dout_valid == 0
- err  output  1  sticky flag; set by an illegal launch or update

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Per-warp state (warp_state_t):
  - IDLE: not launched.
  - READY: eligible for issue.
  - FETCHING: issued; waiting for feedback.
- Reset (rst high at a clk edge, overrides rdy):
  - All warps go to IDLE; per-warp PC and split number clear to 0.
  - rr_ptr = RR_RESET_PTR.
  - dout_valid = 0, dout = 0, err = 0.
  - Reset asserted mid-operation discards any pending dout without a handshake.
- All updates below occur only on a clk edge with rdy high.
- Launch: a fire is launch_valid && launch_ready. The slot loads pc and split and goes IDLE -> READY. launch_valid on a non-IDLE slot is ignored and sets err.
- Update:
  - upd_valid on a FETCHING warp:
    - upd_exit = 0: pc <= upd_pc, state FETCHING -> READY.
    - upd_exit = 1: state FETCHING -> IDLE.
  - upd_valid on a warp that is not FETCHING is ignored and sets err.
- Issue slot is free when !dout_valid || dout_ready.
  - If the slot is free and any warp is READY, the round-robin arbiter grants the first READY warp at or after rr_ptr, wrapping modulo NUM_WARPS.
  - On a grant: dout <= {pc, warp, split}, dout_valid <= 1, the warp goes READY -> FETCHING, rr_ptr <= grant + 1 (mod NUM_WARPS).
  - If the slot is free and no warp is READY, dout_valid <= 0.
- Arbitration reads registered state only. A warp launched or resumed at edge N can therefore issue no earlier than edge N+1, so dout_valid rises in the cycle after N+1.
- Throughput is one issue per cycle while dout_ready stays high and warps are READY.
- dout is stable while dout_valid && !dout_ready.
- Simultaneous events:
  - Launch and update to different warps in the same cycle both apply.
  - A launch and an update to the same slot cannot both be legal; the legal one applies and the other sets err.
  - An issue and an update in the same cycle always target different warps, because the issued warp is READY.
- rdy low: no state changes and err holds. Handshakes fired while rdy is low are not accepted; upstream must hold its requests.

Decomposition:
- Add to gelato_types:
  - warp_state_t enum {WARP_IDLE, WARP_READY, WARP_FETCHING}.
  - NUM_WARPS constant.
  - Existing pc_info_t is reused unchanged.
- Sub-module gelato_rr_arbiter #(N):
  - Inputs: req[N], ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational and reused later by the issue stage.

Test Plan:
- Reset, then launch warp 0 at pc=0x1000, split=2. dout_valid rises one cycle after the launch edge with dout={0x1000, 0, 2}, and active_mask=4'b0001.
- Launch warps 0-3 (pcs 0x100, 0x200, 0x300, 0x400) with dout_ready held high. Issue order is 0, 1, 2, 3, then no further issue until feedback arrives; all warps are FETCHING.
- Hold dout_ready=0 for 5 cycles with warps 1 and 2 READY. dout stays constant at warp 1; after release, warp 2 issues on the next cycle.
- Update warp 1 with upd_pc=0x204. Warp 1 re-issues with pc 0x204. Then update with upd_exit=1: active_mask bit 1 clears and launch_ready for slot 1 returns high.
- Update an IDLE warp and launch an active warp. Both are ignored, err goes to 1 and stays 1 until rst.
- Assert rst while dout_valid=1 and warps are FETCHING. Next cycle dout_valid=0, active_mask=0, all_idle=1, err=0.
